// File: rtl/fpu_pkg.sv
// Shared widths, case encoding and constants
// for the normalise pipeline.
package fpu_pkg;

  localparam int MANT_W_DEF = 25;
  localparam int EXP_W_DEF  = 8;

  localparam logic [EXP_W_DEF-1:0] EXP_ONES = '1;

  typedef enum logic [2:0] {
    CARRY,
    ZERO,
    NORM,
    LEFT,
    DENORM
  } case_e;

endpackage

// File: rtl/lzc.sv
// Priority leading-zero counter, combinational.
// All-zero input yields W.
module lzc #(
  parameter int W  = 24,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d_i,
  output logic [CW-1:0] cnt_o
);

  // highest set bit wins: later iterations override
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (d_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/normalise_pipe.sv
// Two-stage mantissa normaliser: S1 counts
// leading zeros and classifies, S2 shifts.
module normalise_pipe
  import fpu_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_uf,
  output logic              out_of
);

  localparam int LZ_W = $clog2(MANT_W);
  localparam logic [EXP_W-1:0] E_ONES = '1;
  localparam logic [EXP_W-1:0] E_ONE  = EXP_W'(1);

  // stage handshake
  logic s2_adv;
  logic s1_load;
  logic s2_load;

  // stage 1 state
  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q, s1_sign_d;
  logic [MANT_W-1:0] s1_mant_q, s1_mant_d;
  logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
  logic [LZ_W-1:0]   s1_lz_q, s1_lz_d;
  case_e             s1_case_q, s1_case_d;

  // stage 2 (output) state
  logic              out_valid_q, out_valid_d;
  logic              out_sign_q, out_sign_d;
  logic [MANT_W-1:0] out_mant_q, out_mant_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic              out_zero_q, out_zero_d;
  logic              out_uf_q, out_uf_d;
  logic              out_of_q, out_of_d;

  // S1 decode
  logic [LZ_W-1:0]  lz;
  logic [EXP_W-1:0] lz_e;
  logic             is_carry;
  logic             is_zero;
  logic             is_norm;
  logic             is_left;
  logic             is_den;
  case_e            cls;

  // S2 result
  logic [MANT_W-1:0] r_mant;
  logic [EXP_W-1:0]  r_exp;
  logic              r_zero;
  logic              r_uf;
  logic              r_of;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_adv;

  lzc #(
    .W  (MANT_W - 1),
    .CW (LZ_W)
  ) u_lzc (
    .d_i   (in_mant[MANT_W-2:0]),
    .cnt_o (lz)
  );

  assign lz_e     = EXP_W'(lz);
  assign is_carry = in_mant[MANT_W-1];
  assign is_zero  = (in_mant == '0);
  assign is_norm  = !is_carry && (lz == '0);
  assign is_left  = !is_carry && !is_zero
                 && (lz != '0) && (in_exp > lz_e);
  assign is_den   = !is_carry && !is_zero
                 && (lz != '0) && (in_exp <= lz_e);

  // classify operand; terms are mutually exclusive
  always_comb begin
    cls = NORM;
    unique case (1'b1)
      is_carry: cls = CARRY;
      is_zero:  cls = ZERO;
      is_norm:  cls = NORM;
      is_left:  cls = LEFT;
      is_den:   cls = DENORM;
      default:  cls = NORM;
    endcase
  end

  // S1 next state: load on input transfer
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mant_d  = s1_mant_q;
    s1_exp_d   = s1_exp_q;
    s1_lz_d    = s1_lz_q;
    s1_case_d  = s1_case_q;
    if (in_ready) s1_valid_d = in_valid;
    if (s1_load) begin
      s1_sign_d = in_sign;
      s1_mant_d = in_mant;
      s1_exp_d  = in_exp;
      s1_lz_d   = lz;
      s1_case_d = cls;
    end
  end

  // S1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_lz_q    <= '0;
      s1_case_q  <= NORM;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mant_q  <= s1_mant_d;
      s1_exp_q   <= s1_exp_d;
      s1_lz_q    <= s1_lz_d;
      s1_case_q  <= s1_case_d;
    end
  end

  // S2 shift and exponent adjust; exponent
  // never wraps thanks to the S1 guards
  always_comb begin
    r_mant = s1_mant_q;
    r_exp  = s1_exp_q;
    r_zero = 1'b0;
    r_uf   = 1'b0;
    r_of   = 1'b0;
    unique case (s1_case_q)
      CARRY: begin
        if (s1_exp_q >= E_ONES - E_ONE) begin
          r_mant = '0;
          r_exp  = E_ONES;
          r_of   = 1'b1;
        end else begin
          r_mant = s1_mant_q >> 1;
          r_exp  = s1_exp_q + E_ONE;
        end
      end
      ZERO: begin
        r_mant = '0;
        r_exp  = '0;
        r_zero = 1'b1;
      end
      LEFT: begin
        r_mant = s1_mant_q << s1_lz_q;
        r_exp  = s1_exp_q - EXP_W'(s1_lz_q);
      end
      DENORM: begin
        if (s1_exp_q != '0)
          r_mant = s1_mant_q << (s1_exp_q - E_ONE);
        r_exp = '0;
        r_uf  = 1'b1;
      end
      default: begin
        r_mant = s1_mant_q;
        r_exp  = s1_exp_q;
      end
    endcase
  end

  // S2 next state: hold while stalled
  always_comb begin
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_zero_d  = out_zero_q;
    out_uf_d    = out_uf_q;
    out_of_d    = out_of_q;
    if (s2_adv) out_valid_d = s1_valid_q;
    if (s2_load) begin
      out_sign_d = s1_sign_q;
      out_mant_d = r_mant;
      out_exp_d  = r_exp;
      out_zero_d = r_zero;
      out_uf_d   = r_uf;
      out_of_d   = r_of;
    end
  end

  // S2 (output) register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= 1'b0;
      out_uf_q    <= 1'b0;
      out_of_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_zero_q  <= out_zero_d;
      out_uf_q    <= out_uf_d;
      out_of_q    <= out_of_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_zero  = out_zero_q;
  assign out_uf    = out_uf_q;
  assign out_of    = out_of_q;

endmodule

// File: tb/tb_normalise_pipe.sv
// Scoreboard bench: two instances (25/8 and
// 11/5) driven in lockstep.
module tb_normalise_pipe;
  import fpu_pkg::*;

  typedef struct packed {
    logic        s;
    logic        z;
    logic        u;
    logic        o;
    logic [15:0] e;
    logic [31:0] m;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_sign = 1'b0;
  logic out_ready = 1'b0;

  logic [24:0] a_mant = '0;
  logic [7:0]  a_exp = '0;
  logic        a_in_ready, a_out_valid, a_out_sign;
  logic [24:0] a_out_mant;
  logic [7:0]  a_out_exp;
  logic        a_out_zero, a_out_uf, a_out_of;

  logic [10:0] b_mant = '0;
  logic [4:0]  b_exp = '0;
  logic        b_in_ready, b_out_valid, b_out_sign;
  logic [10:0] b_out_mant;
  logic [4:0]  b_out_exp;
  logic        b_out_zero, b_out_uf, b_out_of;

  res_t qa[$];
  res_t qb[$];
  int   checks = 0;
  int   errors = 0;
  res_t a_held;
  bit   a_held_v = 0;
  bit   rnd_done = 0;

  always #5 clk = ~clk;

  normalise_pipe #(.MANT_W(25), .EXP_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_sign(in_sign), .in_mant(a_mant),
    .in_exp(a_exp),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sign(a_out_sign), .out_mant(a_out_mant),
    .out_exp(a_out_exp), .out_zero(a_out_zero),
    .out_uf(a_out_uf), .out_of(a_out_of)
  );

  normalise_pipe #(.MANT_W(11), .EXP_W(5)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_sign(in_sign), .in_mant(b_mant),
    .in_exp(b_exp),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sign(b_out_sign), .out_mant(b_out_mant),
    .out_exp(b_out_exp), .out_zero(b_out_zero),
    .out_uf(b_out_uf), .out_of(b_out_of)
  );

  // reference: rules applied with plain integers
  function automatic res_t model(bit s, longint m,
                                 longint e, int mw,
                                 int ew);
    res_t   r;
    longint emax;
    longint lz;
    int     p;
    r = '0;
    r.s = s;
    emax = (longint'(1) << ew) - 1;
    if (((m >> (mw - 1)) & 1) == 1) begin
      if (e >= emax - 1) begin
        r.e = 16'(emax);
        r.o = 1'b1;
      end else begin
        r.m = 32'(m / 2);
        r.e = 16'(e + 1);
      end
    end else if (m == 0) begin
      r.z = 1'b1;
    end else begin
      p = 0;
      for (int i = 0; i < mw - 1; i++)
        if (((m >> i) & 1) == 1) p = i;
      lz = longint'(mw - 2 - p);
      if (lz == 0) begin
        r.m = 32'(m);
        r.e = 16'(e);
      end else if (e > lz) begin
        r.m = 32'(m * (longint'(1) << lz));
        r.e = 16'(e - lz);
      end else begin
        r.m = (e == 0) ? 32'(m)
            : 32'(m * (longint'(1) << (e - 1)));
        r.u = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic res_t mk(bit s, bit z, bit u,
                              bit o, int e, int m);
    res_t r;
    r.s = s; r.z = z; r.u = u; r.o = o;
    r.e = 16'(e);
    r.m = 32'(m);
    return r;
  endfunction

  function automatic res_t got_a();
    return {a_out_sign, a_out_zero, a_out_uf,
            a_out_of, 16'(a_out_exp),
            32'(a_out_mant)};
  endfunction

  function automatic res_t got_b();
    return {b_out_sign, b_out_zero, b_out_uf,
            b_out_of, 16'(b_out_exp),
            32'(b_out_mant)};
  endfunction

  task automatic chk(string nm, res_t got,
                     res_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got s%0d z%0d u%0d o%0d e=%h m=%h required s%0d z%0d u%0d o%0d e=%h m=%h",
               nm, got.s, got.z, got.u, got.o,
               got.e, got.m, exp.s, exp.z, exp.u,
               exp.o, exp.e, exp.m);
    end
  endtask

  task automatic chk_bit(string nm, logic got,
                         logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b required %b",
               nm, got, exp);
    end
  endtask

  // issue one operand; expectation pushed on
  // acceptance (hx selects a fixed expectation)
  task automatic send(bit s, logic [24:0] ma,
                      logic [7:0] ea,
                      logic [10:0] mb,
                      logic [4:0] eb, bit hx,
                      res_t xa);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    in_valid = 1'b1;
    in_sign = s;
    a_mant = ma; a_exp = ea;
    b_mant = mb; b_exp = eb;
    while (!acc && n < 2000) begin
      @(posedge clk);
      acc = a_in_ready;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got none required accept");
    end else begin
      qa.push_back(hx ? xa
        : model(s, longint'(ma), longint'(ea), 25, 8));
      qb.push_back(
        model(s, longint'(mb), longint'(eb), 11, 5));
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic rnd_op(output logic [24:0] ma,
                        output logic [7:0] ea,
                        output logic [10:0] mb,
                        output logic [4:0] eb);
    int k;
    k = $urandom_range(0, 9);
    ma = 25'($urandom) >> $urandom_range(0, 24);
    mb = 11'($urandom) >> $urandom_range(0, 11);
    if (k == 0) begin
      ma = '0;
      mb = '0;
    end else if (k < 3) begin
      ma[24] = 1'b1;
      mb[10] = 1'b1;
    end
    k = $urandom_range(0, 3);
    ea = 8'($urandom);
    eb = 5'($urandom);
    if (k == 0) begin
      ea = 8'($urandom_range(0, 26));
      eb = 5'($urandom_range(0, 12));
    end else if (k == 1) begin
      ea = 8'($urandom_range(252, 255));
      eb = 5'($urandom_range(28, 31));
    end
  endtask

  task automatic lat_check(string nm);
    @(negedge clk);
    chk_bit({nm, "_c1"}, a_out_valid, 1'b0);
    @(negedge clk);
    chk_bit({nm, "_c2"}, a_out_valid, 1'b1);
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0)
           && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain got %0d left required 0",
               nm, qa.size() + qb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: pop on output transfer, and
  // watch stability while stalled
  always @(negedge clk) begin
    if (rst) begin
      a_held_v = 0;
    end else begin
      if (a_out_valid && out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected got output required none");
        end else begin
          chk("a_result", got_a(), qa.pop_front());
        end
      end
      if (b_out_valid && out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected got output required none");
        end else begin
          chk("b_result", got_b(), qb.pop_front());
        end
      end
      if (a_out_valid && !out_ready) begin
        if (a_held_v) chk("a_stable", got_a(), a_held);
        a_held = got_a();
        a_held_v = 1;
      end else begin
        a_held_v = 0;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] ma;
    logic [7:0]  ea;
    logic [10:0] mb;
    logic [4:0]  eb;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_bit("rst_valid_a", a_out_valid, 1'b0);
    chk_bit("rst_valid_b", b_out_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_bit("rst_inready", a_in_ready, 1'b1);
    chk("rst_out_a", got_a(), '0);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // directed vectors with fixed expectations
    send(0, 25'h0400000, 8'h80, 11'h0F0, 5'h03, 1,
         mk(0, 0, 0, 0, 8'h7F, 25'h0800000));
    lat_check("latency");
    send(0, 25'h1000000, 8'h80, 11'h400, 5'h10, 1,
         mk(0, 0, 0, 0, 8'h81, 25'h0800000));
    send(0, 25'h1000000, 8'hFE, 11'h400, 5'h1E, 1,
         mk(0, 0, 0, 1, EXP_ONES, 0));
    send(0, 25'h0000001, 8'h05, 11'h001, 5'h02, 1,
         mk(0, 0, 1, 0, 0, 25'h0000010));
    send(0, 25'h0000000, 8'h33, 11'h000, 5'h07, 1,
         mk(0, 1, 0, 0, 0, 0));
    send(1, 25'h0800001, 8'h10, 11'h3FF, 5'h00, 1,
         mk(1, 0, 0, 0, 8'h10, 25'h0800001));
    send(0, 25'h0000100, 8'h00, 11'h010, 5'h00, 1,
         mk(0, 0, 1, 0, 0, 25'h0000100));
    send(0, 25'h1000003, 8'hFD, 11'h401, 5'h1D, 1,
         mk(0, 0, 0, 0, 8'hFE, 25'h0800001));
    send(1, 25'h1FFFFFF, 8'hFF, 11'h7FF, 5'h1F, 1,
         mk(1, 0, 0, 1, 8'hFF, 0));
    send(0, 25'h0000100, 8'd16, 11'h010, 5'd5, 1,
         mk(0, 0, 0, 0, 1, 25'h0800000));
    send(0, 25'h0000100, 8'd15, 11'h010, 5'd4, 1,
         mk(0, 0, 1, 0, 0, 25'h0400000));
    drain("directed");

    // stall: two held then in_ready drops
    out_ready = 1'b0;
    send(0, 25'h0123456, 8'h40, 11'h123, 5'h09, 0, '0);
    send(1, 25'h1234567, 8'h41, 11'h456, 5'h0A, 0, '0);
    @(negedge clk);
    chk_bit("full_inready", a_in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    drain("stall");

    // stream of 10 with out_ready low 3 cycles
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rnd_op(ma, ea, mb, eb);
          send(1'($urandom), ma, ea, mb, eb, 0, '0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_bit("stream_inready", a_in_ready, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stream");

    // reset with two operands in flight
    out_ready = 1'b0;
    send(0, 25'h0400000, 8'h20, 11'h100, 5'h08, 0, '0);
    send(0, 25'h0200000, 8'h21, 11'h080, 5'h09, 0, '0);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    @(posedge clk);
    @(negedge clk);
    chk_bit("rst_flush_a", a_out_valid, 1'b0);
    chk_bit("rst_flush_b", b_out_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(0, 25'h0000003, 8'h40, 11'h003, 5'h10, 0, '0);
    lat_check("post_rst");
    drain("post_rst");

    // random run with random backpressure
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          rnd_op(ma, ea, mb, eb);
          send(1'($urandom), ma, ea, mb, eb, 0, '0);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
